// File: rtl/magic_nor_sequencer.sv
// MAGIC NOR-only netlist evaluator: one INIT/NOR micro-op per cycle over a modelled crossbar row.
// Optional armed-cell tracking with a sticky init_err flag is built when MAGIC_INIT_CHECK_EN is defined.
module magic_nor_sequencer #(
  parameter int NUM_CELLS  = 64,
  parameter int NUM_IN     = 10,
  parameter int NUM_OUT    = 1,
  parameter int FANIN      = 3,
  parameter int PROG_DEPTH = 64,
  parameter int AW         = $clog2(NUM_CELLS),
  parameter int PW         = $clog2(PROG_DEPTH),
  parameter int IW         = 2 + AW*(1+FANIN) + FANIN
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               prog_we,
  input  logic [PW-1:0]      prog_addr,
  input  logic [IW-1:0]      prog_data,
  input  logic               start,
  input  logic [NUM_IN-1:0]  in_data,
  output logic               busy,
  output logic               done,
  output logic [NUM_OUT-1:0] out_data,
  output logic [PW:0]        step_count,
  output logic               init_err
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EXEC, S_DONE} state_e;

  localparam logic [1:0] OP_INIT = 2'b01;
  localparam logic [1:0] OP_NOR  = 2'b10;
  localparam logic [1:0] OP_HALT = 2'b11;

  logic [IW-1:0]        prog_mem [PROG_DEPTH];
  state_e               state_q, state_d;
  logic [PW-1:0]        pc_q, pc_d;
  logic [PW:0]          step_q, step_d;
  logic [NUM_CELLS-1:0] cell_q, cell_d;
  logic [NUM_OUT-1:0]   out_q, out_d;

  logic [IW-1:0]              ins;
  logic [1:0]                 op;
  logic [AW-1:0]              dst;
  logic [FANIN-1:0][AW-1:0]   src;
  logic [FANIN-1:0]           mask;
  logic [FANIN-1:0]           src_bit;
  logic                       dst_ok;
  logic                       nor_any;

  assign ins  = prog_mem[pc_q];
  assign op   = ins[IW-1 -: 2];
  assign dst  = ins[IW-3 -: AW];
  assign src  = ins[FANIN + AW*FANIN - 1 : FANIN];
  assign mask = ins[FANIN-1:0];

  // Out-of-range indices only exist when the row is not a power of two.
  generate
    if ((1 << AW) == NUM_CELLS) begin : g_pow2
      assign dst_ok = 1'b1;
      for (genvar k = 0; k < FANIN; k++) begin : g_rd
        assign src_bit[k] = cell_q[src[k]];
      end
    end else begin : g_npow2
      assign dst_ok = (int'(dst) < NUM_CELLS);
      for (genvar k = 0; k < FANIN; k++) begin : g_rd
        assign src_bit[k] = (int'(src[k]) < NUM_CELLS) ? cell_q[src[k]] : 1'b0;
      end
    end
  endgenerate

  assign nor_any = |(src_bit & mask);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    step_d  = step_q;
    cell_d  = cell_q;
    out_d   = out_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_LOAD;
      S_LOAD: begin
        cell_d[NUM_IN-1:0] = in_data;
        pc_d    = '0;
        step_d  = '0;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        step_d = step_q + 1'b1;
        // MAGIC NOR can only discharge the pre-initialised destination.
        if (dst_ok) begin
          if (op == OP_INIT)     cell_d[dst] = 1'b1;
          else if (op == OP_NOR) cell_d[dst] = cell_q[dst] & ~nor_any;
        end
        if (op == OP_HALT || pc_q == PW'(PROG_DEPTH-1)) begin
          state_d = S_DONE;
          out_d   = cell_d[NUM_CELLS-1 -: NUM_OUT];
        end else begin
          pc_d = pc_q + 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      step_q  <= '0;
      cell_q  <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      step_q  <= step_d;
      cell_q  <= cell_d;
      out_q   <= out_d;
    end
  end

  always_ff @(posedge clk) begin
    if (prog_we && !busy) prog_mem[prog_addr] <= prog_data;
  end

  assign busy       = (state_q == S_LOAD) || (state_q == S_EXEC);
  assign done       = (state_q == S_DONE);
  assign out_data   = out_q;
  assign step_count = step_q;

`ifdef MAGIC_INIT_CHECK_EN
  logic [NUM_CELLS-1:0] arm_q, arm_d;
  logic                 err_q, err_d;

  always_comb begin
    arm_d = arm_q;
    err_d = err_q;
    if (state_q == S_LOAD) begin
      arm_d[NUM_IN-1:0] = '1;
      err_d = 1'b0;
    end else if (state_q == S_EXEC && dst_ok) begin
      if (op == OP_INIT) begin
        arm_d[dst] = 1'b1;
      end else if (op == OP_NOR) begin
        arm_d[dst] = 1'b0;
        if (!arm_q[dst]) err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arm_q <= '0;
      err_q <= 1'b0;
    end else begin
      arm_q <= arm_d;
      err_q <= err_d;
    end
  end

  assign init_err = err_q;
`else
  assign init_err = 1'b0;
`endif

endmodule

// File: tb/tb_magic_nor_sequencer.sv
// Bench for magic_nor_sequencer: table vectors, a 10-input netlist sweep and multi-cycle corner cases.
module tb_magic_nor_sequencer;
  localparam int AW = 6, PW = 6, IW = 29, NI = 10;
  localparam logic [1:0] NOP = 2'd0, INIT = 2'd1, NOR = 2'd2, HALT = 2'd3;

  logic clk = 1'b0, rst_n = 1'b0, prog_we = 1'b0, start = 1'b0;
  logic [PW-1:0] prog_addr = '0;
  logic [IW-1:0] prog_data = '0;
  logic [NI-1:0] in_data = '0;
  logic busy, done, init_err, busy2, done2, init_err2;
  logic [0:0] out_data, out2;
  logic [PW:0] step_count, step2;

  always #5 clk = ~clk;

  magic_nor_sequencer dut (
    .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .start(start), .in_data(in_data), .busy(busy), .done(done), .out_data(out_data),
    .step_count(step_count), .init_err(init_err));

  // Non-power-of-two row so out-of-range indices are encodable.
  magic_nor_sequencer #(.NUM_CELLS(48)) dut2 (
    .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .start(start), .in_data(in_data), .busy(busy2), .done(done2), .out_data(out2),
    .step_count(step2), .init_err(init_err2));

  int errs = 0, checks = 0, np = 0;

  typedef struct { int out; int steps; int lat; } exp_t;
  exp_t sb[$];
  typedef struct { logic [NI-1:0] din; int exp; } vec_t;
  vec_t tv[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [IW-1:0] ins(input logic [1:0] op, input int d, input int a, input int b,
                                        input int c, input logic [2:0] m);
    return {op, 6'(d), 6'(c), 6'(b), 6'(a), m};
  endfunction

  task automatic emit(input logic [IW-1:0] x);
    prog_we = 1'b1; prog_addr = PW'(np); prog_data = x;
    @(negedge clk);
    prog_we = 1'b0;
    np++;
  endtask

  task automatic gate(input int d, input int a, input int b, input int c, input int n);
    emit(ins(INIT, d, 0, 0, 0, 3'b000));
    emit(ins(NOR, d, a, b, c, 3'((1 << n) - 1)));
  endtask

  // poke: mid-run start pulse and program write, both of which must be ignored.
  task automatic run(input logic [NI-1:0] din, input int eo, input int es, input int el, input bit poke);
    exp_t e, g;
    int cyc;
    e = '{eo, es, el};
    sb.push_back(e);
    in_data = din; start = 1'b1;
    @(negedge clk);
    start = 1'b0; cyc = 0;
    while (!done && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (poke && cyc == 10) begin
        start = 1'b1; prog_we = 1'b1; prog_addr = 6'd5; prog_data = ins(HALT, 0, 0, 0, 0, 3'b000);
      end else if (poke && cyc == 11) begin
        start = 1'b0; prog_we = 1'b0;
      end
    end
    g = sb.pop_front();
    chk("done_latency", cyc, g.lat);
    if (g.out >= 0) chk("out_data", {31'd0, out_data}, g.out);
    chk("step_count", {25'd0, step_count}, g.steps);
    chk("busy_at_done", {31'd0, busy}, 0);
    @(negedge clk);
  endtask

  function automatic int golden(input logic [NI-1:0] x);
    return int'(((x[0] & x[1] & x[2]) | (x[3] & ~x[4]) | ~(x[5] | x[6] | x[7])) & (x[8] ^ x[9]));
  endfunction

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tv[0] = '{10'h000, 0}; tv[1] = '{10'h001, 1}; tv[2] = '{10'h002, 1}; tv[3] = '{10'h003, 1};
    tv[4] = '{10'h004, 1}; tv[5] = '{10'h005, 1}; tv[6] = '{10'h006, 1}; tv[7] = '{10'h3F8, 0};

    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_out", {31'd0, out_data}, 0);
    chk("rst_steps", {25'd0, step_count}, 0);
    chk("rst_init_err", {31'd0, init_err}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Inverter
    np = 0;
    emit(ins(INIT, 63, 0, 0, 0, 3'b000));
    emit(ins(NOR, 63, 0, 0, 0, 3'b001));
    emit(ins(HALT, 0, 0, 0, 0, 3'b000));
    run(10'h001, 0, 3, 4, 0);
    run(10'h000, 1, 3, 4, 0);

    // 3-input NOR followed by inverter gives OR
    np = 0;
    gate(20, 0, 1, 2, 3);
    gate(63, 20, 0, 0, 1);
    emit(ins(HALT, 0, 0, 0, 0, 3'b000));
    for (int i = 0; i < 8; i++) run(tv[i].din, tv[i].exp, 5, 6, 0);

    // 10-input NOR-mapped netlist
    np = 0;
    gate(10, 0, 0, 0, 1); gate(11, 1, 0, 0, 1); gate(12, 2, 0, 0, 1); gate(13, 3, 0, 0, 1);
    gate(14, 10, 11, 12, 3); gate(15, 13, 4, 0, 2); gate(16, 5, 6, 7, 3);
    gate(17, 8, 9, 0, 2); gate(18, 8, 17, 0, 2); gate(19, 9, 17, 0, 2); gate(20, 18, 19, 0, 2);
    gate(21, 14, 15, 16, 3); gate(63, 21, 20, 0, 2);
    emit(ins(HALT, 0, 0, 0, 0, 3'b000));
    for (int v = 0; v < 1024; v++) run(NI'(v), golden(NI'(v)), 27, 28, 0);

    // src == dst reads the old value
    np = 0;
    emit(ins(INIT, 63, 0, 0, 0, 3'b000));
    emit(ins(NOR, 63, 63, 0, 0, 3'b001));
    emit(ins(HALT, 0, 0, 0, 0, 3'b000));
    run(10'h000, 0, 3, 4, 0);

    // Empty mask leaves dst unchanged
    np = 0;
    emit(ins(INIT, 63, 0, 0, 0, 3'b000));
    emit(ins(NOR, 63, 0, 0, 0, 3'b000));
    emit(ins(HALT, 0, 0, 0, 0, 3'b000));
    run(10'h001, 1, 3, 4, 0);

    // Async reset mid-EXEC
    np = 0;
    emit(ins(INIT, 63, 0, 0, 0, 3'b000));
    for (int i = 0; i < 20; i++) emit(ins(NOP, 0, 0, 0, 0, 3'b000));
    emit(ins(HALT, 0, 0, 0, 0, 3'b000));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_run_busy", {31'd0, busy}, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_done", {31'd0, done}, 0);
    chk("abort_out", {31'd0, out_data}, 0);
    chk("abort_steps", {25'd0, step_count}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    np = 0;
    emit(ins(HALT, 0, 0, 0, 0, 3'b000));
    run(10'h000, 0, 1, 2, 0);
    np = 0;
    emit(ins(INIT, 63, 0, 0, 0, 3'b000));
    emit(ins(NOR, 63, 0, 0, 0, 3'b001));
    emit(ins(HALT, 0, 0, 0, 0, 3'b000));
    run(10'h000, 1, 3, 4, 0);

    // No HALT: runs the full program memory; mid-run start/prog_we ignored
    np = 0;
    emit(ins(INIT, 63, 0, 0, 0, 3'b000));
    for (int i = 1; i < 64; i++) emit(ins(NOP, 0, 0, 0, 0, 3'b000));
    run(10'h000, 1, 64, 65, 1);
    chk("start_while_busy_ignored", {31'd0, busy}, 0);
    repeat (2) @(negedge clk);
    chk("out_hold", {31'd0, out_data}, 1);
    run(10'h000, 1, 64, 65, 0);

    // Out-of-range indices on the 48-cell instance
    np = 0;
    emit(ins(INIT, 47, 0, 0, 0, 3'b000));
    emit(ins(INIT, 49, 0, 0, 0, 3'b000));
    emit(ins(NOR, 47, 49, 0, 0, 3'b001));
    emit(ins(NOR, 49, 0, 0, 0, 3'b001));
    emit(ins(HALT, 0, 0, 0, 0, 3'b000));
    run(10'h001, -1, 5, 6, 0);
    chk("oob_out", {31'd0, out2}, 1);
    chk("oob_steps", {25'd0, step2}, 5);

`ifdef MAGIC_INIT_CHECK_EN
    np = 0;
    emit(ins(NOR, 30, 0, 0, 0, 3'b001));
    emit(ins(HALT, 0, 0, 0, 0, 3'b000));
    run(10'h000, -1, 2, 3, 0);
    chk("init_err_set", {31'd0, init_err}, 1);
    np = 0;
    emit(ins(INIT, 30, 0, 0, 0, 3'b000));
    emit(ins(NOR, 30, 0, 0, 0, 3'b001));
    emit(ins(HALT, 0, 0, 0, 0, 3'b000));
    run(10'h000, -1, 3, 4, 0);
    chk("init_err_cleared", {31'd0, init_err}, 0);
`else
    chk("init_err_tied", {31'd0, init_err}, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
